// File: rtl/ras_return_checker.sv
// ras_return_checker: queues RAS-predicted jalrs in program order and checks
// each prediction against the resolved target when execute retires it.
// A wrong target, or a pc that does not match the head, triggers a one-cycle
// redirect and flushes every younger (wrong-path) entry.
module ras_return_checker #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,   // power of 2, at least 2
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clk_en,
    input  logic                     flush_valid,
    input  logic                     enq_valid,
    output logic                     enq_ready,
    input  logic [WIDTH-1:0]         enq_pc,
    input  logic [WIDTH-1:0]         enq_pred,
    input  logic                     res_valid,
    input  logic [WIDTH-1:0]         res_pc,
    input  logic [WIDTH-1:0]         res_target,
    output logic                     redirect_valid,
    output logic [WIDTH-1:0]         redirect_pc,
    output logic [$clog2(DEPTH):0]   count,
    output logic [CNT_W-1:0]         mispredict_cnt,
    output logic                     err
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    // Entry storage, one pc and one predicted target per slot.
    logic [WIDTH-1:0] pc_mem   [DEPTH];
    logic [WIDTH-1:0] pred_mem [DEPTH];

    // Pointers carry one extra bit so that full and empty are distinguishable.
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;

    logic [WIDTH-1:0] head_pc;
    logic [WIDTH-1:0] head_pred;
    logic             empty;
    logic             full;
    logic             active;
    logic             res_fire;
    logic             res_on_empty;
    logic             pc_mismatch;
    logic             mispredict;
    logic             pop;
    logic             enq_fire;

    assign count     = wr_ptr - rd_ptr;
    assign empty     = (count == '0);
    assign full      = (count == PW'(DEPTH));
    // Ready comes from registered state only; a same-cycle pop does not help.
    assign enq_ready = !full;

    assign head_pc   = pc_mem[rd_ptr[AW-1:0]];
    assign head_pred = pred_mem[rd_ptr[AW-1:0]];

    // Decode the resolve outcome for this cycle and decide whether to enqueue.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no latch is inferred.
        active       = 1'b0;
        res_fire     = 1'b0;
        res_on_empty = 1'b0;
        pc_mismatch  = 1'b0;
        mispredict   = 1'b0;
        pop          = 1'b0;
        enq_fire     = 1'b0;

        active   = clk_en && !flush_valid;
        res_fire = res_valid && active;
        if (res_fire) begin
            if (empty) begin
                res_on_empty = 1'b1;
            end else if (head_pc != res_pc) begin
                // Wrong head is a protocol error but recovers like a mispredict.
                pc_mismatch = 1'b1;
                mispredict  = 1'b1;
            end else if (head_pred != res_target) begin
                mispredict = 1'b1;
            end else begin
                pop = 1'b1;
            end
        end
        // An enqueue alongside a mispredict is wrong-path and is dropped.
        enq_fire = enq_valid && enq_ready && active && !mispredict;
    end

    // Write accepted entries into the circular buffer.
    // NOTE: the storage array has no reset; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (enq_fire) begin
            pc_mem[wr_ptr[AW-1:0]]   <= enq_pc;
            pred_mem[wr_ptr[AW-1:0]] <= enq_pred;
        end
    end

    // Pointer, redirect, counter and error state.
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            mispredict_cnt <= '0;
            err            <= 1'b0;
        end else if (flush_valid) begin
            rd_ptr         <= wr_ptr;
            redirect_valid <= 1'b0;
        end else if (clk_en) begin
            if (res_on_empty || pc_mismatch) begin
                err <= 1'b1;
            end
            if (mispredict) begin
                rd_ptr         <= wr_ptr;
                redirect_valid <= 1'b1;
                redirect_pc    <= res_target;
                if (mispredict_cnt != '1) begin
                    mispredict_cnt <= mispredict_cnt + CNT_W'(1);
                end
            end else begin
                redirect_valid <= 1'b0;
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                if (enq_fire) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
            end
        end
    end

endmodule
